// File: rtl/present_decrypt_core.sv
// PRESENT block-cipher decryption core, one round per clock.
// The forward key schedule first derives K32, then rounds 31..1 are peeled off with the inverse layers.
module present_decrypt_core #(
    parameter int KEY_LEN = 80
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [63:0]        data_i,
    input  logic [KEY_LEN-1:0] key_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [63:0]        data_o
);

    localparam int CNT_LSB = (KEY_LEN == 128) ? 62 : 15;

    generate
        if (KEY_LEN != 80 && KEY_LEN != 128) begin : gen_bad_key_len
            $error("present_decrypt_core: KEY_LEN must be 80 or 128");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        KEYGEN,
        DECRYPT,
        DONE
    } state_e;

    state_e             fsm_q, fsm_d;
    logic [63:0]        block_q, block_d;
    logic [KEY_LEN-1:0] key_q, key_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [63:0]        dout_q, dout_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] invSbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Forward schedule step: rotate left by 61, S-box on the top nibble(s), fold in the round counter.
    function automatic logic [KEY_LEN-1:0] fwdUpd(input logic [KEY_LEN-1:0] k, input logic [4:0] rc);
        logic [KEY_LEN-1:0] r;
        r = {k[KEY_LEN-62:0], k[KEY_LEN-1:KEY_LEN-61]};
        r[KEY_LEN-1 -: 4] = sbox(r[KEY_LEN-1 -: 4]);
        if (KEY_LEN == 128) begin
            r[KEY_LEN-5 -: 4] = sbox(r[KEY_LEN-5 -: 4]);
        end
        r[CNT_LSB +: 5] = r[CNT_LSB +: 5] ^ rc;
        return r;
    endfunction

    function automatic logic [KEY_LEN-1:0] invUpd(input logic [KEY_LEN-1:0] k, input logic [4:0] rc);
        logic [KEY_LEN-1:0] r;
        r = k;
        r[CNT_LSB +: 5] = r[CNT_LSB +: 5] ^ rc;
        r[KEY_LEN-1 -: 4] = invSbox(r[KEY_LEN-1 -: 4]);
        if (KEY_LEN == 128) begin
            r[KEY_LEN-5 -: 4] = invSbox(r[KEY_LEN-5 -: 4]);
        end
        return {r[60:0], r[KEY_LEN-1:61]};
    endfunction

    function automatic logic [63:0] invPLayer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 63; i++) begin
            y[i] = x[(16 * i) % 63];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [63:0] invSLayer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = invSbox(x[4*i +: 4]);
        end
        return y;
    endfunction

    logic [KEY_LEN-1:0] keyFwd;
    logic [KEY_LEN-1:0] keyInv;
    logic [63:0]        roundOut;

    always_comb begin
        fwd_defaults: begin
            fsm_d   = fsm_q;
            block_d = block_q;
            key_d   = key_q;
            cnt_d   = cnt_q;
            dout_d  = dout_q;
        end
        keyFwd   = fwdUpd(key_q, cnt_q);
        keyInv   = invUpd(key_q, cnt_q);
        roundOut = invSLayer(invPLayer(block_q)) ^ keyInv[KEY_LEN-1 -: 64];

        case (fsm_q)
            IDLE: begin
                if (in_valid_i) begin
                    block_d = data_i;
                    key_d   = key_i;
                    cnt_d   = 5'd1;
                    fsm_d   = KEYGEN;
                end
            end
            KEYGEN: begin
                key_d = keyFwd;
                if (cnt_q == 5'd31) begin
                    // Final forward step yields K32, which whitens the ciphertext before round 31 is undone.
                    block_d = block_q ^ keyFwd[KEY_LEN-1 -: 64];
                    fsm_d   = DECRYPT;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DECRYPT: begin
                block_d = roundOut;
                key_d   = keyInv;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    dout_d = roundOut;
                    fsm_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            block_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            block_q <= block_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign in_ready_o  = (fsm_q == IDLE);
    assign out_valid_o = (fsm_q == DONE);
    assign data_o      = dout_q;

endmodule

// File: tb/tb_present_decrypt_core.sv
// Directed and round-trip bench for present_decrypt_core, with one instance for each key length.
// An independent PRESENT encryption model produces the ciphertexts used by the round-trip test.
module tb_present_decrypt_core;

    logic         clk;
    logic         rstN;

    logic         iv80, ir80, ov80, or80;
    logic [63:0]  din80, dout80;
    logic [79:0]  key80;

    logic         iv128, ir128, ov128, or128;
    logic [63:0]  din128, dout128;
    logic [127:0] key128;

    int checks;
    int errors;

    present_decrypt_core #(.KEY_LEN(80)) dut80 (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .in_valid_i (iv80),
        .in_ready_o (ir80),
        .data_i     (din80),
        .key_i      (key80),
        .out_valid_o(ov80),
        .out_ready_i(or80),
        .data_o     (dout80)
    );

    present_decrypt_core #(.KEY_LEN(128)) dut128 (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .in_valid_i (iv128),
        .in_ready_o (ir128),
        .data_i     (din128),
        .key_i      (key128),
        .out_valid_o(ov128),
        .out_ready_i(or128),
        .data_o     (dout128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a handshake hangs somewhere the bounded waits do not cover.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired before the summary");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [3:0] sboxFwd(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
            4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
            4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
            4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Straightforward PRESENT encryption: addRoundKey, sBoxLayer, pLayer, key update; final K32 whitening.
    function automatic logic [63:0] presentEnc(input logic [63:0] pt, input logic [127:0] keyIn, input bit is128);
        logic [127:0] k;
        logic [79:0]  k80;
        logic [63:0]  s;
        logic [63:0]  t;
        k = keyIn;
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ (is128 ? k[127:64] : k[79:16]);
            for (int n = 0; n < 16; n++) begin
                s[4*n +: 4] = sboxFwd(s[4*n +: 4]);
            end
            for (int b = 0; b < 63; b++) begin
                t[(16 * b) % 63] = s[b];
            end
            t[63] = s[63];
            s = t;
            if (is128) begin
                k = {k[66:0], k[127:67]};
                k[127:124] = sboxFwd(k[127:124]);
                k[123:120] = sboxFwd(k[123:120]);
                k[66:62]   = k[66:62] ^ 5'(r);
            end else begin
                k80 = k[79:0];
                k80 = {k80[18:0], k80[79:19]};
                k80[79:76] = sboxFwd(k80[79:76]);
                k80[19:15] = k80[19:15] ^ 5'(r);
                k = {48'd0, k80};
            end
        end
        s = s ^ (is128 ? k[127:64] : k[79:16]);
        return s;
    endfunction

    // Offer one block to the 80-bit core; afterwards the inputs are scrambled to show they are not re-sampled.
    task automatic applyStimulus(input logic [63:0] ct, input logic [79:0] key);
        @(negedge clk);
        iv80  = 1'b1;
        din80 = ct;
        key80 = key;
        @(posedge clk);
        #1;
        iv80  = 1'b0;
        din80 = ~ct;
        key80 = ~key;
    endtask

    // Counts edges after acceptance until out_valid_o rises; 0 means it never did within the budget.
    task automatic waitDone80(output int lat);
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov80) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release80();
        @(negedge clk);
        or80 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or80 = 1'b0;
        checks++;
        if (ov80 !== 1'b0 || ir80 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release80 out_valid=%b in_ready=%b want 0/1", ov80, ir80);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        #12;
        checks++;
        if (ir80 !== 1'b1 || ov80 !== 1'b0 || dout80 !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset80 ready=%b valid=%b data=%h want 1/0/0", ir80, ov80, dout80);
        end
        checks++;
        if (ir128 !== 1'b1 || ov128 !== 1'b0 || dout128 !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset128 ready=%b valid=%b data=%h want 1/0/0", ir128, ov128, dout128);
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_known_vectors();
        logic [63:0] cts [4];
        logic [63:0] pts [4];
        logic [79:0] keys[4];
        int          lat;
        cts[0] = 64'h5579C1387B228445; keys[0] = 80'h0;                    pts[0] = 64'h0;
        cts[1] = 64'hE72C46C0F5945049; keys[1] = 80'hFFFFFFFFFFFFFFFFFFFF; pts[1] = 64'h0;
        cts[2] = 64'hA112FFC72F68417B; keys[2] = 80'h0;                    pts[2] = 64'hFFFFFFFFFFFFFFFF;
        cts[3] = 64'h3333DCD3213210D2; keys[3] = 80'hFFFFFFFFFFFFFFFFFFFF; pts[3] = 64'hFFFFFFFFFFFFFFFF;
        for (int v = 0; v < 4; v++) begin
            applyStimulus(cts[v], keys[v]);
            waitDone80(lat);
            checks++;
            if (lat !== 62) begin
                errors++;
                $display("[TB] FAIL known%0d_latency got %0d want 62", v, lat);
            end
            checks++;
            if (dout80 !== pts[v]) begin
                errors++;
                $display("[TB] FAIL known%0d_data got %h want %h", v, dout80, pts[v]);
            end
            release80();
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        applyStimulus(64'h5579C1387B228445, 80'h0);
        repeat (39) @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checks++;
        if (ir80 !== 1'b1 || ov80 !== 1'b0 || dout80 !== 64'd0) begin
            errors++;
            $display("[TB] FAIL midreset_clear ready=%b valid=%b data=%h want 1/0/0", ir80, ov80, dout80);
        end
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(64'h5579C1387B228445, 80'h0);
        waitDone80(lat);
        checks++;
        if (lat !== 62) begin
            errors++;
            $display("[TB] FAIL midreset_latency got %0d want 62", lat);
        end
        checks++;
        if (dout80 !== 64'd0) begin
            errors++;
            $display("[TB] FAIL midreset_data got %h want 0000000000000000", dout80);
        end
        release80();
    endtask

    task automatic test_hold_and_back_to_back();
        int lat;
        applyStimulus(64'hA112FFC72F68417B, 80'h0);
        waitDone80(lat);
        checks++;
        if (lat !== 62) begin
            errors++;
            $display("[TB] FAIL hold_latency got %0d want 62", lat);
        end
        for (int c = 0; c < 10; c++) begin
            iv80  = 1'b1;
            din80 = {$urandom(), $urandom()};
            key80 = {16'(c), $urandom(), $urandom()};
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ov80 !== 1'b1 || ir80 !== 1'b0 || dout80 !== 64'hFFFFFFFFFFFFFFFF) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d valid=%b ready=%b data=%h want 1/0/ffffffffffffffff",
                         c, ov80, ir80, dout80);
            end
        end
        // in_valid stays high across the handoff edge; the core may only take it one cycle later.
        din80 = 64'hE72C46C0F5945049;
        key80 = 80'hFFFFFFFFFFFFFFFFFFFF;
        or80  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or80 = 1'b0;
        checks++;
        if (ov80 !== 1'b0 || ir80 !== 1'b1 || dout80 !== 64'hFFFFFFFFFFFFFFFF) begin
            errors++;
            $display("[TB] FAIL handoff valid=%b ready=%b data=%h want 0/1/ffffffffffffffff", ov80, ir80, dout80);
        end
        @(posedge clk);
        #1;
        iv80  = 1'b0;
        din80 = 64'h0123456789ABCDEF;
        key80 = 80'h0;
        waitDone80(lat);
        checks++;
        if (lat !== 62) begin
            errors++;
            $display("[TB] FAIL b2b_latency got %0d want 62", lat);
        end
        checks++;
        if (dout80 !== 64'd0) begin
            errors++;
            $display("[TB] FAIL b2b_data got %h want 0000000000000000", dout80);
        end
        release80();
    endtask

    task automatic test_random_roundtrip();
        logic [63:0]  pt;
        logic [95:0]  rnd96;
        logic [79:0]  k80;
        logic [127:0] k128;
        logic [63:0]  ct80, ct128;
        int           lat;
        for (int i = 0; i < 400; i++) begin
            pt    = {$urandom(), $urandom()};
            rnd96 = {$urandom(), $urandom(), $urandom()};
            k80   = rnd96[79:0];
            k128  = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct80  = presentEnc(pt, {48'd0, k80}, 1'b0);
            ct128 = presentEnc(pt, k128, 1'b1);
            @(negedge clk);
            iv80   = 1'b1; din80  = ct80;  key80  = k80;
            iv128  = 1'b1; din128 = ct128; key128 = k128;
            @(posedge clk);
            #1;
            iv80  = 1'b0; din80  = ~ct80;  key80  = ~k80;
            iv128 = 1'b0; din128 = ~ct128; key128 = ~k128;
            lat = 0;
            for (int n = 1; n <= 100; n++) begin
                @(posedge clk);
                @(negedge clk);
                if (ov80 || ov128) begin
                    lat = n;
                    break;
                end
            end
            checks++;
            if (lat !== 62 || ov80 !== 1'b1 || ov128 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rand%0d_timing lat=%0d valid80=%b valid128=%b want 62/1/1", i, lat, ov80, ov128);
            end
            checks++;
            if (dout80 !== pt) begin
                errors++;
                $display("[TB] FAIL rand%0d_data80 got %h want %h", i, dout80, pt);
            end
            checks++;
            if (dout128 !== pt) begin
                errors++;
                $display("[TB] FAIL rand%0d_data128 got %h want %h", i, dout128, pt);
            end
            @(negedge clk);
            or80  = 1'b1;
            or128 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            or80  = 1'b0;
            or128 = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        iv80   = 1'b0; or80  = 1'b0; din80  = '0; key80  = '0;
        iv128  = 1'b0; or128 = 1'b0; din128 = '0; key128 = '0;
        rstN   = 1'b1;

        test_reset();
        test_known_vectors();
        test_mid_reset();
        test_hold_and_back_to_back();
        test_random_roundtrip();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
